// File: rtl/cd4022_pkg.sv
// Shared types and constants for the CD4022 sequence monitor.
// Holds the FSM states, fault codes and the stage-to-carry mapping.
package cd4022_pkg;

   localparam int STAGES = 8;

   typedef enum logic [1:0] {
      SYNC,
      TRACK,
      FAULT
   } state_t;

   localparam logic [1:0] ERR_NONE   = 2'd0;
   localparam logic [1:0] ERR_ONEHOT = 2'd1;
   localparam logic [1:0] ERR_CARRY  = 2'd2;
   localparam logic [1:0] ERR_STEP   = 2'd3;

   // Carry is high for stages 0-3 and low for stages 4-7.
   function automatic logic expected_carry(input logic [2:0] index);
      return (index < 3'd4);
   endfunction

endpackage

// File: rtl/cd4022_onehot_decode.sv
// Combinational one-hot check and binary index of eight stage outputs.
// The index is only meaningful when onehot is high.
module cd4022_onehot_decode
   import cd4022_pkg::*;
(
   input  logic [STAGES-1:0] stage_bits,
   output logic              onehot,
   output logic [2:0]        index
);

   logic [3:0] ones;

   always_comb begin
      ones  = 4'd0;
      index = 3'd0;
      for (int i = 0; i < STAGES; i++) begin
         if (stage_bits[i]) begin
            ones  = ones + 4'd1;
            index = 3'(i);
         end
      end
      onehot = (ones == 4'd1);
   end

endmodule

// File: rtl/cd4022_sequence_monitor.sv
// Reconstructs the CD4022 binary count, counts 7->0 wraps and
// latches the first illegal pattern or step until cleared.
module cd4022_sequence_monitor
   import cd4022_pkg::*;
#(
   parameter int CYCLE_WIDTH = 16
) (
   input  logic                   CLOCK,
   input  logic                   RESET,
   input  logic [7:0]             OUT_IN,
   input  logic                   CARRY_IN,
   input  logic                   CLEAR_ERROR,
   output logic [2:0]             COUNT,
   output logic                   COUNT_VALID,
   output logic                   STEP,
   output logic                   RESYNC,
   output logic [CYCLE_WIDTH-1:0] CYCLES,
   output logic                   ERROR,
   output logic [1:0]             ERROR_CODE
);

   logic [7:0] out_q;
   logic       carry_q;
   logic       onehot;
   logic [2:0] index;
   logic       carry_ok;
   logic       legal;
   logic [2:0] count_inc;

   state_t                 state_q, state_d;
   logic [2:0]             count_q, count_d;
   logic [CYCLE_WIDTH-1:0] cycles_q, cycles_d;
   logic                   step_q, step_d;
   logic                   resync_q, resync_d;
   logic [1:0]             code_q, code_d;

   // Reset value decodes as a legal stage-0 sample.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         out_q   <= 8'h01;
         carry_q <= 1'b1;
      end else begin
         out_q   <= OUT_IN;
         carry_q <= CARRY_IN;
      end
   end

   cd4022_onehot_decode u_decode (
      .stage_bits (out_q),
      .onehot     (onehot),
      .index      (index)
   );

   assign carry_ok  = (carry_q == expected_carry(index));
   assign legal     = onehot && carry_ok;
   assign count_inc = count_q + 3'd1;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      cycles_d = cycles_q;
      code_d   = code_q;
      step_d   = 1'b0;
      resync_d = 1'b0;
      unique case (state_q)
         SYNC: begin
            if (legal) begin
               state_d = TRACK;
               count_d = index;
            end
         end
         TRACK: begin
            if (!onehot) begin
               state_d = FAULT;
               code_d  = ERR_ONEHOT;
            end else if (!carry_ok) begin
               state_d = FAULT;
               code_d  = ERR_CARRY;
            end else if (index == count_q) begin
               count_d = count_q;
            end else if (index == count_inc) begin
               count_d = index;
               step_d  = 1'b1;
               if (count_q == 3'd7)
                  cycles_d = cycles_q + {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
            end else if (index == 3'd0) begin
               count_d  = index;
               resync_d = 1'b1;
            end else begin
               state_d = FAULT;
               code_d  = ERR_STEP;
            end
         end
         FAULT: begin
            if (CLEAR_ERROR) begin
               state_d = SYNC;
               code_d  = ERR_NONE;
            end
         end
         default: begin
            state_d = SYNC;
            code_d  = ERR_NONE;
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= SYNC;
         count_q  <= 3'd0;
         cycles_q <= '0;
         step_q   <= 1'b0;
         resync_q <= 1'b0;
         code_q   <= ERR_NONE;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         cycles_q <= cycles_d;
         step_q   <= step_d;
         resync_q <= resync_d;
         code_q   <= code_d;
      end
   end

   assign COUNT       = count_q;
   assign COUNT_VALID = (state_q == TRACK);
   assign STEP        = step_q;
   assign RESYNC      = resync_q;
   assign CYCLES      = cycles_q;
   assign ERROR       = (state_q == FAULT);
   assign ERROR_CODE  = code_q;

endmodule

// File: tb/tb_cd4022_sequence_monitor.sv
// Directed bench for cd4022_sequence_monitor.
// Outputs trail the applied sample by one extra edge.
module tb_cd4022_sequence_monitor;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  OUT_IN = 8'h01;
   logic        CARRY_IN = 1'b1;
   logic        CLEAR_ERROR = 1'b0;
   logic [2:0]  COUNT;
   logic        COUNT_VALID;
   logic        STEP;
   logic        RESYNC;
   logic [15:0] CYCLES;
   logic        ERROR;
   logic [1:0]  ERROR_CODE;

   int vectors = 0;
   int miscompares = 0;

   cd4022_sequence_monitor #(.CYCLE_WIDTH(16)) dut (
      .CLOCK       (CLOCK),
      .RESET       (RESET),
      .OUT_IN      (OUT_IN),
      .CARRY_IN    (CARRY_IN),
      .CLEAR_ERROR (CLEAR_ERROR),
      .COUNT       (COUNT),
      .COUNT_VALID (COUNT_VALID),
      .STEP        (STEP),
      .RESYNC      (RESYNC),
      .CYCLES      (CYCLES),
      .ERROR       (ERROR),
      .ERROR_CODE  (ERROR_CODE)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [7:0] o, input logic c);
      OUT_IN   = o;
      CARRY_IN = c;
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".count"}, COUNT, 0);
      chk({tag, ".valid"}, COUNT_VALID, 0);
      chk({tag, ".step"}, STEP, 0);
      chk({tag, ".resync"}, RESYNC, 0);
      chk({tag, ".cycles"}, CYCLES, 0);
      chk({tag, ".error"}, ERROR, 0);
      chk({tag, ".code"}, ERROR_CODE, 0);
   endtask

   initial begin
      // reset
      apply(8'h01, 1'b1);
      apply(8'h01, 1'b1);
      chk_reset("rst");
      RESET = 1'b0;

      // clean sequence 0..7,0..7
      for (int k = 0; k < 16; k++) begin
         apply(8'(1 << (k % 8)), (k % 8) < 4);
         if (k == 1) begin
            chk("seq.valid", COUNT_VALID, 1);
            chk("seq.first_step", STEP, 0);
            chk("seq.first_count", COUNT, 0);
         end else if (k >= 2) begin
            chk("seq.step", STEP, 1);
            chk("seq.count", COUNT, (k - 1) % 8);
         end
      end
      apply(8'h01, 1'b1);
      chk("seq.cycles1", CYCLES, 1);
      apply(8'h02, 1'b1);
      chk("seq.cycles2", CYCLES, 2);
      chk("seq.error", ERROR, 0);

      // inhibit at stage 3
      apply(8'h04, 1'b1);
      apply(8'h08, 1'b1);
      apply(8'h08, 1'b1);
      chk("inh.enter_step", STEP, 1);
      chk("inh.enter_count", COUNT, 3);
      for (int k = 0; k < 4; k++) begin
         apply(k == 3 ? 8'h10 : 8'h08, k == 3 ? 1'b0 : 1'b1);
         chk("inh.hold_step", STEP, 0);
         chk("inh.hold_count", COUNT, 3);
      end
      apply(8'h20, 1'b0);
      chk("inh.resume_step", STEP, 1);
      chk("inh.resume_count", COUNT, 4);

      // counter reset from stage 5
      apply(8'h01, 1'b1);
      chk("rsy.count5", COUNT, 5);
      apply(8'h02, 1'b1);
      chk("rsy.pulse", RESYNC, 1);
      chk("rsy.nostep", STEP, 0);
      chk("rsy.count", COUNT, 0);
      chk("rsy.cycles", CYCLES, 2);
      chk("rsy.error", ERROR, 0);
      apply(8'h04, 1'b1);
      chk("rsy.one_shot", RESYNC, 0);
      chk("rsy.step_after", STEP, 1);

      // skip 2 -> 4
      apply(8'h10, 1'b0);
      chk("skp.count2", COUNT, 2);
      apply(8'h10, 1'b0);
      chk("skp.error", ERROR, 1);
      chk("skp.code", ERROR_CODE, 3);
      chk("skp.count", COUNT, 2);
      chk("skp.valid", COUNT_VALID, 0);
      apply(8'h0C, 1'b1);
      chk("skp.code_held", ERROR_CODE, 3);
      chk("skp.count_frozen", COUNT, 2);
      chk("skp.cycles_frozen", CYCLES, 2);

      // not one-hot
      CLEAR_ERROR = 1'b1;
      apply(8'h01, 1'b1);
      CLEAR_ERROR = 1'b0;
      chk("clr.error", ERROR, 0);
      chk("clr.code", ERROR_CODE, 0);
      chk("clr.valid", COUNT_VALID, 0);
      apply(8'h0C, 1'b1);
      chk("clr.revalid", COUNT_VALID, 1);
      chk("clr.count", COUNT, 0);
      apply(8'h01, 1'b1);
      chk("oh.code", ERROR_CODE, 1);
      chk("oh.error", ERROR, 1);

      // carry mismatch
      CLEAR_ERROR = 1'b1;
      apply(8'h01, 1'b1);
      CLEAR_ERROR = 1'b0;
      apply(8'h20, 1'b1);
      chk("cy.valid", COUNT_VALID, 1);
      apply(8'h01, 1'b1);
      chk("cy.code", ERROR_CODE, 2);
      chk("cy.error", ERROR, 1);
      chk("cy.valid_low", COUNT_VALID, 0);
      CLEAR_ERROR = 1'b1;
      apply(8'h01, 1'b1);
      CLEAR_ERROR = 1'b0;
      apply(8'h02, 1'b1);
      chk("cy.revalid", COUNT_VALID, 1);
      chk("cy.cycles", CYCLES, 2);

      // run one more wrap to reach CYCLES=3
      for (int i = 2; i < 8; i++)
         apply(8'(1 << i), i < 4);
      apply(8'h01, 1'b1);
      apply(8'h02, 1'b1);
      chk("wrap.cycles3", CYCLES, 3);
      chk("wrap.count", COUNT, 0);
      apply(8'h04, 1'b1);
      chk("wrap.count1", COUNT, 1);

      // reset mid-sequence, together with clear
      RESET = 1'b1;
      CLEAR_ERROR = 1'b1;
      apply(8'h08, 1'b1);
      chk_reset("mid");
      RESET = 1'b0;
      CLEAR_ERROR = 1'b0;
      apply(8'h01, 1'b1);
      chk("mid.valid", COUNT_VALID, 1);
      chk("mid.count", COUNT, 0);
      chk("mid.cycles", CYCLES, 0);
      apply(8'h02, 1'b1);
      chk("mid.hold", STEP, 0);
      apply(8'h04, 1'b1);
      chk("mid.step", STEP, 1);
      chk("mid.count1", COUNT, 1);
      chk("mid.error", ERROR, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cd4022_sequence_monitor.md
# cd4022_sequence_monitor

Receive-side companion to the CD4022 divide-by-8 counter: samples the eight decoded stage outputs and the carry output, reconstructs the binary count, tracks completed divide-by-8 cycles, and flags any illegal pattern or illegal step. It sits on the consuming side of a CD4022 instance. It is used both as synthesizable glue logic that needs a binary count and as a self-checking monitor in counter benches.

## Interface
- CYCLE_WIDTH, 16: width of the completed-cycle counter.
- CLOCK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  reset, synchronous and active-high; one clock; reset is synchronous and active-high.
- OUT_IN  input  8  decoded stage outputs from the counter; exactly one bit high when legal.
- CARRY_IN  input  1  counter carry output; must be high for stages 0-3 and low for stages 4-7.
- CLEAR_ERROR  input  1  leaves FAULT; ignored in other states.
- COUNT  output  3  binary index of the last legal sample.
- COUNT_VALID  output  1  high in TRACK only.
- STEP  output  1  one-cycle pulse when the index advanced by +1 (mod 8).
- RESYNC  output  1  one-cycle pulse on a jump to index 0 from 1-6 (counter reset).
- CYCLES  output  CYCLE_WIDTH  count of 7->0 wraps; wraps modulo 2^CYCLE_WIDTH.
- ERROR  output  1  high while in FAULT.
- ERROR_CODE  output  2  0 none, 1 not one-hot, 2 carry mismatch, 3 illegal step.

## Operation
- Stage 1 registers OUT_IN and CARRY_IN unconditionally.
- Stage 2 decodes the registered sample into three results: one-hot legal, index, and expected carry (index < 4).
- Legal sample: exactly one bit set and CARRY matches the expected carry.
- State SYNC: on a legal sample, load COUNT with the index, go to TRACK, and raise COUNT_VALID. Illegal samples are ignored, with no error.
- State TRACK, for each sample against the previous COUNT:
  - Same index: hold (counter inhibited or stalled). No pulse.
  - Index = COUNT+1 mod 8: update COUNT and pulse STEP. If 7->0, also increment CYCLES.
  - Index 0 from COUNT 1-6: update COUNT and pulse RESYNC. CYCLES is unchanged.
  - Any other index: go to FAULT with code 3.
  - Not one-hot: go to FAULT with code 1. This check takes priority over the carry check.
  - Carry mismatch: go to FAULT with code 2.
- State FAULT: ERROR=1, COUNT_VALID=0. COUNT and CYCLES freeze. ERROR_CODE holds the first fault's code.
- CLEAR_ERROR in FAULT goes to SYNC and clears ERROR and ERROR_CODE on the same edge.
- RESET takes priority over everything. Reset values: COUNT=0, COUNT_VALID=0, STEP=0, RESYNC=0, CYCLES=0, ERROR=0, ERROR_CODE=0, state SYNC. Reset also clears the stage-1 registers to OUT=8'b0000_0001, CARRY=1.

## Timing
- Latency is two edges. An input change before edge N is reflected on all outputs after edge N+1.
- STEP and RESYNC are high for exactly one cycle per event. They are never both high.
- A CD4022 step every cycle produces STEP every cycle. CYCLES increments once per eight STEPs in steady state.
- The first legal sample after SYNC entry produces no STEP.
- Reset mid-operation: outputs take reset values after the edge on which RESET is high. The first legal sample after RESET deasserts re-enters TRACK.
- Simultaneous RESET and CLEAR_ERROR: RESET wins, with an identical end state.

## Structure
- Package cd4022_pkg holds:
  - the state enum {SYNC, TRACK, FAULT};
  - the ERROR_CODE constants ERR_NONE, ERR_ONEHOT, ERR_CARRY, ERR_STEP;
  - the constant STAGES=8;
  - the function that maps an index to its expected carry.
- Sub-module cd4022_onehot_decode is combinational. Input is 8 bits. Outputs are legal one-hot (1 bit) and index (3 bits). It is reusable by other counter monitors.
- The top level holds the stage-1 registers, the FSM, and the output registers.

## Test plan
- Reset, then feed a clean sequence 0..7,0..7 (OUT_IN=1<<i, CARRY=i<4) one step per cycle. Expected: COUNT_VALID after the 2nd edge, STEP every cycle after the first, CYCLES=2 after the second 7->0, ERROR=0.
- Hold OUT_IN=8'h08 for 5 cycles mid-sequence (inhibit), then resume. Expected: COUNT=3 held, no STEP during the hold, STEP on resume.
- At index 5, apply OUT_IN=8'h01, CARRY=1 (counter reset). Expected: one RESYNC pulse, COUNT=0, CYCLES unchanged, no ERROR.
- At index 2, apply OUT_IN=8'h10 (skip). Expected: ERROR=1, ERROR_CODE=3, COUNT frozen at 2, COUNT_VALID=0.
- Apply OUT_IN=8'h0C, then OUT_IN=8'h20 with CARRY=1, each in its own run with CLEAR_ERROR between. Expected: code 1, then code 2. CLEAR_ERROR returns to SYNC, and the next legal sample restores COUNT_VALID.
- Assert RESET mid-sequence with CYCLES=3. Expected: all outputs at reset values next edge, and tracking restarts on the first legal sample.
